// File: rtl/output_reorder_stream_pkg.sv
// -----------------------------------------------------------------------------
// output_reorder_stream_pkg
// Shared types and helpers for the FFT output reorder buffer.
//   complex_product_t : one complex sample (.r, .i), same layout as the FFT
//                       datapath's common complex product type
//   REORDER_N / REORDER_LOG2N : default frame size and index width
//   reorder_bank_t    : one frame of samples at the default size
//   log2n()           : index width for a power-of-two frame size
//   bit_reverse()     : reverse the low 'width' bits of an index
// Optional feature macro used by this block: OUTPUT_REORDER_FRAME_CHECK_EN
// -----------------------------------------------------------------------------
package output_reorder_stream_pkg;

  typedef struct packed {
    logic signed [15:0] r;
    logic signed [15:0] i;
  } complex_product_t;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  localparam int REORDER_N     = 16;
  localparam int REORDER_LOG2N = log2n(REORDER_N);

  typedef complex_product_t reorder_bank_t [REORDER_N];

  // Bits at or above 'width' come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] idx, input int width);
    logic [31:0] res;
    logic [4:0]  src;
    res = 32'd0;
    for (int b = 0; b < 32; b++) begin
      if (b < width) begin
        src    = 5'(width - 1 - b);
        res[b] = idx[src];
      end else begin
        res[b] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/output_reorder_stream_if.sv
// -----------------------------------------------------------------------------
// output_reorder_stream_if
// Handshake bundle around the reorder buffer.
//   in_valid/in_ready/in_data      : bit-reversed sample stream from the FFT
//   out_valid/out_ready/out_data   : natural-order sample stream to the demapper
//   out_index/out_last             : natural index of out_data, end of frame
//   in_last/frame_err              : only with OUTPUT_REORDER_FRAME_CHECK_EN
// Modports: slave = the reorder block, master = its surroundings.
// -----------------------------------------------------------------------------
interface output_reorder_stream_if #(
  parameter int N = 16
);
  import output_reorder_stream_pkg::*;

  localparam int LOG2N = log2n(N);

  logic             in_valid;
  logic             in_ready;
  complex_product_t in_data;
  logic             out_valid;
  logic             out_ready;
  complex_product_t out_data;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
`ifdef OUTPUT_REORDER_FRAME_CHECK_EN
  logic             in_last;
  logic             frame_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, frame_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, frame_err
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );
`endif

endinterface

// File: rtl/output_reorder_stream_reorder_bank.sv
// -----------------------------------------------------------------------------
// reorder_bank
// One frame buffer of the ping-pong pair: N-entry sample store with a write
// port, an asynchronous read port and a full flag.
//   clk, reset         : clock, asynchronous active-low reset (flag only)
//   wr_en/wr_addr/wr_data : sample write
//   set_full           : frame complete, mark bank full
//   clr_full           : frame drained, mark bank empty
//   rd_addr/rd_data    : sample read (combinational from storage)
//   full               : bank holds a complete frame
// Storage contents are deliberately not reset.
// -----------------------------------------------------------------------------
module reorder_bank
  import output_reorder_stream_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [log2n(N)-1:0]    wr_addr,
  input  complex_product_t       wr_data,
  input  logic                   set_full,
  input  logic                   clr_full,
  input  logic [log2n(N)-1:0]    rd_addr,
  output complex_product_t       rd_data,
  output logic                   full
);

  complex_product_t mem_r [N];
  logic             full_r;

  // Sample storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Full flag; the controller never sets and clears the same bank together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_r <= 1'b0;
    end else if (set_full) begin
      full_r <= 1'b1;
    end else if (clr_full) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign rd_data = mem_r[rd_addr];
  assign full    = full_r;

endmodule

// File: rtl/output_reorder_stream.sv
// -----------------------------------------------------------------------------
// output_reorder_stream
// Ping-pong reorder buffer behind the FFT: takes one N-point frame in
// bit-reversed order and replays it in natural order 0..N-1.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : output_reorder_stream_if.slave (input and output streams)
// Optional: OUTPUT_REORDER_FRAME_CHECK_EN adds in_last checking and a sticky
// frame_err flag; without it frames are N beats by count alone.
// -----------------------------------------------------------------------------
module output_reorder_stream
  import output_reorder_stream_pkg::*;
#(
  parameter int N = 16
) (
  input logic                    clk,
  input logic                    reset,
  output_reorder_stream_if.slave bus
);

  localparam int LOG2N = log2n(N);
  localparam logic [LOG2N-1:0] CNT_MAX  = {LOG2N{1'b1}};
  localparam logic [LOG2N-1:0] CNT_ZERO = {LOG2N{1'b0}};

  logic             wr_bank_r;
  logic             rd_bank_r;
  logic [LOG2N-1:0] wr_cnt_r;
  logic [LOG2N-1:0] rd_cnt_r;

  logic [1:0]       full_s;
  complex_product_t rd_data_s [2];
  logic [LOG2N-1:0] wr_addr_s;
  logic             in_ready_s;
  logic             wr_fire_s;
  logic             wr_at_end_s;
  logic             wr_drop_s;
  logic             out_valid_s;
  logic             rd_fire_s;
  logic             rd_at_end_s;
  logic [1:0]       wr_en_s;
  logic [1:0]       set_full_s;
  logic [1:0]       clr_full_s;

  // Writer lands each bit-reversed arrival directly at its natural slot.
  assign wr_addr_s   = LOG2N'(bit_reverse(32'(wr_cnt_r), LOG2N));
  assign in_ready_s  = ~full_s[wr_bank_r];
  assign wr_fire_s   = bus.in_valid & in_ready_s;
  assign wr_at_end_s = (wr_cnt_r == CNT_MAX);

  assign out_valid_s = full_s[rd_bank_r];
  assign rd_fire_s   = out_valid_s & bus.out_ready;
  assign rd_at_end_s = (rd_cnt_r == CNT_MAX);

`ifdef OUTPUT_REORDER_FRAME_CHECK_EN
  logic frame_bad_s;
  logic frame_err_r;

  // An early in_last abandons the partial frame; a missing one only flags.
  assign wr_drop_s   = wr_fire_s & bus.in_last & ~wr_at_end_s;
  assign frame_bad_s = wr_drop_s | (wr_fire_s & wr_at_end_s & ~bus.in_last);

  // Sticky framing error, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err_r <= 1'b0;
    end else if (frame_bad_s) begin
      frame_err_r <= 1'b1;
    end else begin
      frame_err_r <= frame_err_r;
    end
  end

  assign bus.frame_err = frame_err_r;
`else
  assign wr_drop_s = 1'b0;
`endif

  // Steer write/commit/release strobes to the bank each pointer selects.
  always_comb begin
    wr_en_s               = 2'b00;
    set_full_s            = 2'b00;
    clr_full_s            = 2'b00;
    wr_en_s[wr_bank_r]    = wr_fire_s;
    set_full_s[wr_bank_r] = wr_fire_s & wr_at_end_s;
    clr_full_s[rd_bank_r] = rd_fire_s & rd_at_end_s;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    reorder_bank #(
      .N (N)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en_s[b]),
      .wr_addr  (wr_addr_s),
      .wr_data  (bus.in_data),
      .set_full (set_full_s[b]),
      .clr_full (clr_full_s[b]),
      .rd_addr  (rd_cnt_r),
      .rd_data  (rd_data_s[b]),
      .full     (full_s[b])
    );
  end

  // Write pointer: count beats, flip banks when a frame is committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_r  <= CNT_ZERO;
      wr_bank_r <= 1'b0;
    end else if (wr_fire_s) begin
      if (wr_at_end_s) begin
        wr_cnt_r  <= CNT_ZERO;
        wr_bank_r <= ~wr_bank_r;
      end else if (wr_drop_s) begin
        wr_cnt_r  <= CNT_ZERO;
        wr_bank_r <= wr_bank_r;
      end else begin
        wr_cnt_r  <= wr_cnt_r + 1'b1;
        wr_bank_r <= wr_bank_r;
      end
    end else begin
      wr_cnt_r  <= wr_cnt_r;
      wr_bank_r <= wr_bank_r;
    end
  end

  // Read pointer: walk natural order, flip banks after the last sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_r  <= CNT_ZERO;
      rd_bank_r <= 1'b0;
    end else if (rd_fire_s) begin
      if (rd_at_end_s) begin
        rd_cnt_r  <= CNT_ZERO;
        rd_bank_r <= ~rd_bank_r;
      end else begin
        rd_cnt_r  <= rd_cnt_r + 1'b1;
        rd_bank_r <= rd_bank_r;
      end
    end else begin
      rd_cnt_r  <= rd_cnt_r;
      rd_bank_r <= rd_bank_r;
    end
  end

  // Outputs come only from pointer/flag registers and storage, so they hold
  // steady while the downstream stalls.
  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = rd_data_s[rd_bank_r];
  assign bus.out_index = rd_cnt_r;
  assign bus.out_last  = out_valid_s & rd_at_end_s;

endmodule
